// File: rtl/rr_bin_arbiter.sv
// rr_bin_arbiter: round-robin arbiter over req_i, registered binary grant_idx_o with valid_o/ready_i handshake (clk, sync active-low reset_n)
module rr_bin_arbiter #(
  parameter int BIN_W = 5,
  parameter int N_REQ = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [BIN_W-1:0] grant_idx_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [BIN_W-1:0] ptr, next_ptr, start, win;
  logic [N_REQ-1:0] rot;
  logic [BIN_W:0] off, sum;
  logic hs, hit;
  assign hs = valid_o & ready_i;
  assign next_ptr = grant_idx_o == BIN_W'(N_REQ - 1) ? '0 : grant_idx_o + 1'b1;
  assign start = hs ? next_ptr : ptr;
  assign rot = N_REQ'({req_i, req_i} >> start);
  assign hit = |req_i;
  assign sum = {1'b0, start} + off;
  assign win = BIN_W'(sum >= (BIN_W+1)'(N_REQ) ? sum - (BIN_W+1)'(N_REQ) : sum);
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = (BIN_W+1)'(i);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      valid_o     <= 1'b0;
      grant_idx_o <= '0;
      ptr         <= '0;
    end else if (state == IDLE) begin
      if (hit) begin
        state       <= GRANT;
        valid_o     <= 1'b1;
        grant_idx_o <= win;
      end
    end else if (ready_i) begin
      ptr     <= next_ptr;
      state   <= hit ? GRANT : IDLE;
      valid_o <= hit;
      if (hit) grant_idx_o <= win;
    end
  end
endmodule

// File: tb/tb_rr_bin_arbiter.sv
// tb_rr_bin_arbiter: directed checks of the round-robin binary arbiter
module tb_rr_bin_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] req_i = '0;
  logic ready_i = 1'b0;
  logic valid_o;
  logic [4:0] grant_idx_o;
  int errors = 0;
  int checks = 0;
  rr_bin_arbiter #(.BIN_W(5), .N_REQ(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_i(req_i),
    .ready_i(ready_i),
    .valid_o(valid_o),
    .grant_idx_o(grant_idx_o)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask
  initial begin
    do_reset();
    chk("rst_valid", valid_o, 0);
    chk("rst_idx", grant_idx_o, 0);
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_valid", valid_o, 0);
    end
    chk("idle_idx", grant_idx_o, 0);
    req_i = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("solo_valid", valid_o, 1);
      chk("solo_idx", grant_idx_o, 0);
    end
    req_i = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      step();
      chk("all_valid", valid_o, 1);
      chk("all_idx", grant_idx_o, i % 32);
    end
    req_i = 32'h0002_0008;
    ready_i = 1'b0;
    do_reset();
    step();
    chk("p_valid", valid_o, 1);
    chk("p_idx", grant_idx_o, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_idx", grant_idx_o, 3);
    end
    req_i = 32'h0002_0000;
    step();
    chk("drop_idx", grant_idx_o, 3);
    chk("drop_valid", valid_o, 1);
    ready_i = 1'b1;
    step();
    chk("b2b_valid", valid_o, 1);
    chk("b2b_idx", grant_idx_o, 17);
    req_i = '0;
    step();
    chk("empty_valid", valid_o, 0);
    chk("empty_idx", grant_idx_o, 17);
    ready_i = 1'b0;
    req_i = 32'h8000_0000;
    step();
    chk("g31_idx", grant_idx_o, 31);
    chk("g31_valid", valid_o, 1);
    req_i = 32'h4000_0001;
    ready_i = 1'b1;
    step();
    chk("wrap_idx0", grant_idx_o, 0);
    step();
    chk("wrap_idx30", grant_idx_o, 30);
    chk("wrap_valid", valid_o, 1);
    ready_i = 1'b0;
    do_reset();
    req_i = 32'h0000_0200;
    step();
    chk("g9_idx", grant_idx_o, 9);
    reset_n = 1'b0;
    ready_i = 1'b1;
    step();
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_idx", grant_idx_o, 0);
    reset_n = 1'b1;
    ready_i = 1'b0;
    req_i = 32'hFFFF_FFFF;
    step();
    chk("post_rst_valid", valid_o, 1);
    chk("post_rst_idx", grant_idx_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
